// File: rtl/fp32_exp_req_arbiter.sv
// Round-robin arbiter sharing one start/done fp32 exp core among NREQ requesters.
// Optional WAIT-state watchdog enabled by defining FP32_EXP_ARB_TIMEOUT_EN.
module fp32_exp_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096,
    localparam int IDX_W      = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_x,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_y,
    output logic                   rsp_err,
    output logic                   core_start,
    output logic [DATA_W-1:0]      core_x,
    input  logic                   core_done,
    input  logic [DATA_W-1:0]      core_y,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_idx
);

    localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [IDX_W-1:0]  r_rrPtr;
    logic [IDX_W-1:0]  r_grantIdx;
    logic [IDX_W-1:0]  w_pickIdx;
    logic              w_pickFound;
    logic [DATA_W-1:0] r_xQ;
    logic [DATA_W-1:0] r_yQ;
    logic              w_timeout;
    logic              w_rspErr;

    function automatic logic [IDX_W-1:0] wrapIdx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDX_W'(s);
    endfunction

    // Scan upward from the round-robin pointer; the first pending requester wins.
    always_comb begin
        w_pickFound = 1'b0;
        w_pickIdx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_pickFound && req_valid[wrapIdx(r_rrPtr, k)]) begin
                w_pickFound = 1'b1;
                w_pickIdx   = wrapIdx(r_rrPtr, k);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_y       = '0;
        rsp_err     = 1'b0;
        core_start  = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // A grant shown during reset would be lost, so hold ready low then.
                if (w_pickFound && !rst) begin
                    req_ready = NREQ'(1) << w_pickIdx;
                end
                if (w_pickFound) begin
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_start  = 1'b1;
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done || w_timeout) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid   = NREQ'(1) << r_grantIdx;
                rsp_y       = r_yQ;
                rsp_err     = w_rspErr;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rrPtr    <= '0;
            r_grantIdx <= '0;
            r_xQ       <= '0;
            r_yQ       <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                ST_IDLE: begin
                    if (w_pickFound) begin
                        r_xQ       <= req_x[int'(w_pickIdx)*DATA_W +: DATA_W];
                        r_grantIdx <= w_pickIdx;
                    end
                end
                ST_WAIT: begin
                    if (core_done) begin
                        r_yQ <= core_y;
                    end else if (w_timeout) begin
                        r_yQ <= QNAN;
                    end
                end
                ST_RESP: begin
                    r_rrPtr <= (r_grantIdx == IDX_W'(NREQ - 1)) ? '0 : r_grantIdx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef FP32_EXP_ARB_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_errQ;

    // The limit is reached on the WAIT cycle whose increment would hit TIMEOUT_CYC.
    assign w_timeout = (r_state == ST_WAIT) && ((r_wdog + 32'd1) == 32'(TIMEOUT_CYC));
    assign w_rspErr  = r_errQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_errQ <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wdog <= r_wdog + 32'd1;
                if (core_done) begin
                    r_errQ <= 1'b0;
                end else if (w_timeout) begin
                    r_errQ <= 1'b1;
                end
            end
        end
    end
`else
    logic w_unusedTimeout;

    assign w_timeout       = 1'b0;
    assign w_rspErr        = 1'b0;
    assign w_unusedTimeout = |TIMEOUT_CYC;
`endif

    assign core_x    = r_xQ;
    assign grant_idx = r_grantIdx;

endmodule

// File: tb/tb_fp32_exp_req_arbiter.sv
// Self-checking bench for fp32_exp_req_arbiter: stub exp core, round-robin reference model,
// directed scenarios followed by randomized transactions.
module tb_fp32_exp_req_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int TMO    = 16;
    localparam logic [31:0] MASK = 32'h813C_5AB2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_x;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_y;
    logic                   rsp_err;
    logic                   core_start;
    logic [DATA_W-1:0]      core_x;
    logic                   core_done;
    logic [DATA_W-1:0]      core_y;
    logic                   busy;
    logic [1:0]             grant_idx;

    int   checks     = 0;
    int   errors     = 0;
    int   modelPtr   = 0;
    int   expStarts  = 0;
    int   startCount = 0;
    bit   monitorOn  = 1'b0;

    logic        stubDone  = 1'b0;
    logic        spurDone  = 1'b0;
    logic [31:0] stubY     = '0;
    logic [31:0] stubX     = '0;
    int          stubCnt   = 0;
    int          stubL     = 1;
    bit          stubNever = 1'b0;

    fp32_exp_req_arbiter #(
        .NREQ(NREQ),
        .DATA_W(DATA_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_x(req_x),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_y(rsp_y),
        .rsp_err(rsp_err),
        .core_start(core_start),
        .core_x(core_x),
        .core_done(core_done),
        .core_y(core_y),
        .busy(busy),
        .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    assign core_done = stubDone | spurDone;
    assign core_y    = stubDone ? stubY : 32'hFFFF_FFFF;

    // Stub core: done is raised L cycles after it sees the start pulse; result is x ^ MASK.
    always @(posedge clk) begin
        stubDone <= 1'b0;
        if (stubCnt > 0) begin
            stubCnt <= stubCnt - 1;
            if (stubCnt == 1) begin
                stubDone <= 1'b1;
                stubY    <= stubX ^ MASK;
            end
        end
        if (core_start && !stubNever) begin
            stubCnt <= stubL;
            stubX   <= core_x;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ*DATA_W-1:0] xs);
        req_valid = valid;
        req_x     = xs;
    endtask

    // Reference arbitration: first valid index at or after the pointer, modulo NREQ.
    function automatic int modelPick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (core_start) startCount++;
        if (monitorOn) begin
            checkOutput("onehot_req_ready", {63'd0, $onehot0(req_ready)}, 64'd1);
            checkOutput("onehot_rsp_valid", {63'd0, $onehot0(rsp_valid)}, 64'd1);
            checkOutput("ready_while_busy", {63'd0, busy && (req_ready != '0)}, 64'd0);
        end
    end

    // One full transaction; expG < 0 means the expected winner comes from the model.
    task automatic runTxn(input string tag, input logic [NREQ-1:0] valid,
                          input logic [NREQ*DATA_W-1:0] xs, input int lat,
                          input bit never, input bit spurResp, input int expG);
        int          g;
        int          rspEdge;
        logic [31:0] expY;
        logic [31:0] expX;
        logic        expErr;
        logic [3:0]  oh;
        g = (expG >= 0) ? expG : modelPick(valid, modelPtr);
        oh = 4'b0001 << g;
        expX = xs[32*g +: 32];
        stubL = lat;
        stubNever = never;
        if (never) begin
            rspEdge = TMO + 1;
            expY    = 32'h7FC0_0000;
            expErr  = 1'b1;
        end else begin
            rspEdge = lat + 2;
            expY    = expX ^ MASK;
            expErr  = 1'b0;
        end
        applyStimulus(valid, xs);
        #1;
        checkOutput({tag, "_ready"}, 64'(req_ready), 64'(oh));
        @(posedge clk); #1;
        applyStimulus(valid & ~oh, xs);
        expStarts++;
        checkOutput({tag, "_start"}, 64'(core_start), 64'd1);
        checkOutput({tag, "_grant"}, 64'(grant_idx), 64'(g));
        checkOutput({tag, "_corex"}, 64'(core_x), 64'(expX));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
        for (int e = 1; e < rspEdge; e++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_early_rsp"}, 64'(rsp_valid), 64'd0);
            checkOutput({tag, "_idle_rspy"}, 64'(rsp_y), 64'd0);
            checkOutput({tag, "_start_once"}, 64'(core_start), 64'd0);
            checkOutput({tag, "_corex_hold"}, 64'(core_x), 64'(expX));
        end
        @(posedge clk); #1;
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(oh));
        checkOutput({tag, "_rsp_y"}, 64'(rsp_y), 64'(expY));
        checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'(expErr));
        if (spurResp) spurDone = 1'b1;
        @(posedge clk); #1;
        spurDone = 1'b0;
        applyStimulus('0, xs);
        checkOutput({tag, "_idle_after"}, 64'(busy), 64'd0);
        checkOutput({tag, "_rsp_once"}, 64'(rsp_valid), 64'd0);
        modelPtr = (g + 1) % NREQ;
    endtask

    initial begin
        logic [NREQ*DATA_W-1:0] xs;
        logic [NREQ-1:0]        v;

        rst = 1'b1;
        applyStimulus('0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_y", 64'(rsp_y), 64'd0);
        checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("reset_core_start", 64'(core_start), 64'd0);
        checkOutput("reset_core_x", 64'(core_x), 64'd0);
        checkOutput("reset_grant_idx", 64'(grant_idx), 64'd0);
        rst = 1'b0;
        monitorOn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] T1 single request");
        xs = {32'h0, 32'h0, 32'h0, 32'hBF80_0000};
        runTxn("T1", 4'b0001, xs, 5, 1'b0, 1'b0, 0);

        $display("[TB] T2 round-robin");
        xs = {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000};
        runTxn("T2a", 4'b1111, xs, 3, 1'b0, 1'b0, 1);
        runTxn("T2b", 4'b1111, xs, 3, 1'b0, 1'b0, 2);
        runTxn("T2c", 4'b1111, xs, 3, 1'b0, 1'b0, 3);
        runTxn("T2d", 4'b1111, xs, 3, 1'b0, 1'b0, 0);
        runTxn("T2e", 4'b1111, xs, 3, 1'b0, 1'b0, 1);

        $display("[TB] T3 wrap and skip");
        runTxn("T3a", 4'b1000, xs, 2, 1'b0, 1'b0, 3);
        runTxn("T3b", 4'b0100, xs, 2, 1'b0, 1'b0, 2);
        runTxn("T3c", 4'b0011, xs, 2, 1'b0, 1'b0, 0);

        $display("[TB] T4 reset during WAIT");
        stubL = 4;
        stubNever = 1'b0;
        applyStimulus(4'b0010, xs);
        #1;
        checkOutput("T4_ready", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        applyStimulus('0, xs);
        expStarts++;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("T4_in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("T4_busy_cleared", 64'(busy), 64'd0);
        checkOutput("T4_no_start", 64'(core_start), 64'd0);
        checkOutput("T4_grant_reset", 64'(grant_idx), 64'd0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            checkOutput("T4_late_done_ignored", 64'(rsp_valid), 64'd0);
            checkOutput("T4_stay_idle", 64'(busy), 64'd0);
        end
        modelPtr = 0;
        runTxn("T4_after", 4'b1001, xs, 2, 1'b0, 1'b0, 0);

        $display("[TB] T5 spurious core_done");
        spurDone = 1'b1;
        @(posedge clk); #1;
        spurDone = 1'b0;
        checkOutput("T5_idle_busy", 64'(busy), 64'd0);
        checkOutput("T5_idle_rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput("T5_idle_busy2", 64'(busy), 64'd0);
        runTxn("T5_resp", 4'b0100, xs, 3, 1'b0, 1'b1, 2);

        $display("[TB] random transactions");
        for (int i = 0; i < 24; i++) begin
            v  = 4'($urandom_range(1, 15));
            xs = {$urandom, $urandom, $urandom, $urandom};
            runTxn("RND", v, xs, int'($urandom_range(1, 6)), 1'b0, 1'($urandom_range(0, 1)), -1);
        end

`ifdef FP32_EXP_ARB_TIMEOUT_EN
        $display("[TB] T6 watchdog timeout");
        xs = {32'h0, 32'h1234_5678, 32'h0, 32'h0};
        runTxn("T6", 4'b0100, xs, 0, 1'b1, 1'b0, -1);
        stubNever = 1'b0;
`else
        $display("[TB] T6 core never responds");
        stubNever = 1'b1;
        xs = {32'h0, 32'h1234_5678, 32'h0, 32'h0};
        applyStimulus(4'b0100, xs);
        #1;
        checkOutput("T6_ready", 64'(req_ready), 64'(4'b0001 << modelPick(4'b0100, modelPtr)));
        @(posedge clk); #1;
        applyStimulus('0, xs);
        expStarts++;
        repeat (10000) @(posedge clk);
        #1;
        checkOutput("T6_still_busy", 64'(busy), 64'd1);
        checkOutput("T6_no_rsp", 64'(rsp_valid), 64'd0);
        checkOutput("T6_no_err", 64'(rsp_err), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("T6_recovered", 64'(busy), 64'd0);
        stubNever = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        monitorOn = 1'b0;
        checkOutput("start_count", 64'(startCount), 64'(expStarts));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
